register_file: RTL

Parametrised multi-port register file for the unicycle processor datapath. It generalises the single storage register to DEPTH entries of WIDTH bits, with one synchronous write port and two asynchronous read ports. It adds optional hardwired-zero entry 0 and optional write-to-read bypass. It sits between the decode stage (register addresses) and the ALU operand inputs, and takes write-back data from the result mux.

---
 rtl/register_file.sv | 75 +++++++
 1 files changed

// File: rtl/register_file.sv
// Multi-port register file: DEPTH x WIDTH storage, one synchronous write port and
// two combinational read ports, with optional hardwired-zero entry 0 and write bypass.
module register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              enable,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [WIDTH-1:0]  rs1_data,
    output logic [WIDTH-1:0]  rs2_data
);

    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             we_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [WIDTH-1:0]  wdata
    );
        logic [WIDTH-1:0] r;
        if (ZERO_REG && (addr == '0)) begin
            r = '0;
        end else if (!in_range(addr)) begin
            r = '0;
        end else if (BYPASS && we && (addr == waddr)) begin
            r = wdata;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Qualified write strobe; reset suppresses both the write and any bypass.
    always_comb begin
        we_s = write && enable && !rst && in_range(rd_addr)
               && !(ZERO_REG && (rd_addr == '0));
    end

    // Storage array: synchronous clear has priority over the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_s) begin
            mem_q[rd_addr] <= data_in;
        end
    end

    // Combinational read ports; the stored operand is only used when in range.
    always_comb begin
        rs1_data = read_port(rs1_addr, mem_q[rs1_addr], we_s, rd_addr, data_in);
        rs2_data = read_port(rs2_addr, mem_q[rs2_addr], we_s, rd_addr, data_in);
    end

endmodule
